// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Request/status bundle between the fetch-control master and
//               the pc_sequencer slave.
// Revision    : 1.0 - initial release
// ============================================================================

interface pc_sequencer_if #(
   parameter int AW = 8
);
   logic          stall;
   logic          br_take;
   logic          call;
   logic          ret;
   logic [AW-1:0] br_target;
   logic [AW-1:0] pc;
   logic          ras_empty;
   logic          ras_full;
   logic          ras_ovf;
   logic          ras_unf;

   modport master (
      output stall, br_take, call, ret, br_target,
      input  pc, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, br_take, call, ret, br_target,
      output pc, ras_empty, ras_full, ras_ovf, ras_unf
   );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC sequencer with a circular return-address stack.
//               Macro PC_SEQ_STICKY_ERR_EN makes ras_ovf/ras_unf sticky.
// Revision    : 1.0 - initial release
// ============================================================================

module pc_sequencer #(
   parameter int            AW        = 8,
   parameter int            RAS_DEPTH = 4,
   parameter logic [AW-1:0] RESET_PC  = '0
) (
   input  wire           clk,
   input  wire           rst,
   pc_sequencer_if.slave bus
);

   localparam int            c_CW       = $clog2(RAS_DEPTH + 1);
   localparam int            c_TW       = $clog2(RAS_DEPTH);
   localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(RAS_DEPTH);
   localparam logic [c_TW-1:0] c_TOP_LAST = c_TW'(RAS_DEPTH - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [AW-1:0]   pc_q,    pc_d;
   logic [c_TW-1:0] top_q,   top_d;
   logic [c_CW-1:0] cnt_q,   cnt_d;
   logic            empty_q, empty_d;
   logic            full_q,  full_d;
   logic            ovf_q,   ovf_d;
   logic            unf_q,   unf_d;
   logic [AW-1:0]   ras_q [RAS_DEPTH];

   // Combinational helpers
   logic [AW-1:0]   w_pc_inc;
   logic [c_TW-1:0] w_top_inc;
   logic [c_TW-1:0] w_top_dec;
   logic            w_empty;
   logic            w_full;
   logic            w_wr_en;
   logic [c_TW-1:0] w_wr_idx;
   logic            w_ovf_ev;
   logic            w_unf_ev;

   assign w_pc_inc  = pc_q + AW'(1);
   assign w_top_inc = (top_q == c_TOP_LAST) ? '0 : top_q + c_TW'(1);
   assign w_top_dec = (top_q == '0) ? c_TOP_LAST : top_q - c_TW'(1);
   assign w_empty   = (cnt_q == '0);
   assign w_full    = (cnt_q == c_CNT_FULL);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         top_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         top_q   <= top_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Every push (plain call, tail-call) stores pc+1, so the write data is fixed.
   generate
      for (genvar g = 0; g < RAS_DEPTH; g++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ras_q[g] <= '0;
            end else if (w_wr_en && (w_wr_idx == c_TW'(g))) begin
               ras_q[g] <= w_pc_inc;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d     = w_pc_inc;
      top_d    = top_q;
      cnt_d    = cnt_q;
      w_wr_en  = 1'b0;
      w_wr_idx = w_top_inc;
      w_ovf_ev = 1'b0;
      w_unf_ev = 1'b0;

      if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.call && bus.ret) begin
         pc_d    = bus.br_target;
         w_wr_en = 1'b1;
         if (w_empty) begin
            top_d = w_top_inc;
            cnt_d = cnt_q + c_CW'(1);
         end else begin
            w_wr_idx = top_q;
         end
      end else if (bus.ret) begin
         if (w_empty) begin
            w_unf_ev = 1'b1;
         end else begin
            pc_d  = ras_q[top_q];
            top_d = w_top_dec;
            cnt_d = cnt_q - c_CW'(1);
         end
      end else if (bus.call) begin
         pc_d    = bus.br_target;
         w_wr_en = 1'b1;
         top_d   = w_top_inc;
         if (w_full) begin
            w_ovf_ev = 1'b1;
         end else begin
            cnt_d = cnt_q + c_CW'(1);
         end
      end else if (bus.br_take) begin
         pc_d = bus.br_target;
      end
   end

   always_comb begin
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == c_CNT_FULL);
`ifdef PC_SEQ_STICKY_ERR_EN
      ovf_d   = ovf_q | w_ovf_ev;
      unf_d   = unf_q | w_unf_ev;
`else
      ovf_d   = w_ovf_ev;
      unf_d   = w_unf_ev;
`endif
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      bus.pc        = pc_q;
      bus.ras_empty = empty_q;
      bus.ras_full  = full_q;
      bus.ras_ovf   = ovf_q;
      bus.ras_unf   = unf_q;
   end

endmodule

`default_nettype wire
